// File: rtl/io_fwd_queue.sv
// rtl/io_fwd_queue.sv - AHB IO slave that replays recorded reads, logs writes and drives IRQ/FIQ
module io_fwd_queue #(
  parameter int          RD_DEPTH = 16,
  parameter int          WR_DEPTH = 8,
  parameter int          NUM_IRQ  = 4,
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] BAD_DATA = 32'hDEADBEEF
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic                      HREQUEST,
  input  logic [31:0]               HADDR,
  input  logic                      HWRITE,
  input  logic [31:0]               HWDATA,
  output logic [31:0]               HRDATA,
  output logic                      HREADY,
  input  logic                      rd_push_valid,
  output logic                      rd_push_ready,
  input  logic [31:0]               rd_push_addr,
  input  logic [31:0]               rd_push_data,
  output logic                      wr_log_valid,
  input  logic                      wr_log_ready,
  output logic [31:0]               wr_log_addr,
  output logic [31:0]               wr_log_data,
  input  logic                      irq_set_valid,
  input  logic [NUM_IRQ-1:0]        irq_set_vec,
  input  logic                      fiq_set,
  output logic [NUM_IRQ-1:0]        irq,
  output logic                      fiq,
  output logic                      err_mismatch,
  output logic                      err_timeout,
  output logic [$clog2(RD_DEPTH):0] rd_count
);

  localparam int RAW = $clog2(RD_DEPTH);
  localparam int WAW = $clog2(WR_DEPTH);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WDATA, RDATA, RWAIT} state_t;

  state_t        state;
  logic [31:0]   addr_d;
  logic [TW-1:0] wait_cnt;
  logic [31:0]   hrdata_q;

  logic [31:0]  rd_addr_mem [RD_DEPTH];
  logic [31:0]  rd_data_mem [RD_DEPTH];
  logic [RAW:0] rd_wp;
  logic [RAW:0] rd_rp;
  logic         rd_empty;
  logic         rd_full;
  logic         rd_push;
  logic         rd_pop;
  logic [31:0]  rd_head_addr;
  logic [31:0]  rd_head_data;

  logic [31:0]  wr_addr_mem [WR_DEPTH];
  logic [31:0]  wr_data_mem [WR_DEPTH];
  logic [WAW:0] wr_wp;
  logic [WAW:0] wr_rp;
  logic         wr_empty;
  logic         wr_full;
  logic         wr_push;
  logic         wr_pop;

  logic in_rd;
  logic rd_hit;
  logic rd_miss;
  logic rd_tmo;
  logic rd_done;
  logic wr_done;
  logic accept;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign rd_empty     = (rd_wp == rd_rp);
  assign rd_full      = (rd_wp[RAW] != rd_rp[RAW]) && (rd_wp[RAW-1:0] == rd_rp[RAW-1:0]);
  assign rd_head_addr = rd_addr_mem[rd_rp[RAW-1:0]];
  assign rd_head_data = rd_data_mem[rd_rp[RAW-1:0]];
  assign rd_push      = rd_push_valid & ~rd_full;
  assign rd_push_ready = ~rd_full;
  assign rd_count     = rd_wp - rd_rp;

  assign wr_empty     = (wr_wp == wr_rp);
  assign wr_full      = (wr_wp[WAW] != wr_rp[WAW]) && (wr_wp[WAW-1:0] == wr_rp[WAW-1:0]);
  assign wr_log_valid = ~wr_empty;
  assign wr_log_addr  = wr_addr_mem[wr_rp[WAW-1:0]];
  assign wr_log_data  = wr_data_mem[wr_rp[WAW-1:0]];
  assign wr_pop       = wr_log_valid & wr_log_ready;

  assign in_rd   = (state == RDATA) || (state == RWAIT);
  assign rd_hit  = in_rd && !rd_empty && (rd_head_addr == addr_d);
  assign rd_miss = in_rd && !rd_empty && (rd_head_addr != addr_d);
  assign rd_tmo  = in_rd && rd_empty && (wait_cnt == TW'(TIMEOUT));
  assign rd_done = rd_hit | rd_miss | rd_tmo;
  assign rd_pop  = rd_hit;
  assign wr_done = (state == WDATA) && !wr_full;
  assign wr_push = wr_done;
  assign HREADY  = (state == IDLE) || rd_done || wr_done;
  assign accept  = HSEL & HREQUEST & HREADY;

  always_comb begin
    HRDATA = hrdata_q;
    if (rd_hit)
      HRDATA = rd_head_data;
    else if (rd_miss || rd_tmo)
      HRDATA = BAD_DATA;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= IDLE;
      addr_d       <= '0;
      wait_cnt     <= '0;
      hrdata_q     <= '0;
      err_mismatch <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      // A completing data phase may accept the next address in the same cycle.
      if (accept) begin
        state  <= HWRITE ? WDATA : RDATA;
        addr_d <= HADDR;
      end else if (HREADY) begin
        state <= IDLE;
      end else if (in_rd) begin
        state <= RWAIT;
      end

      if (rd_done) begin
        wait_cnt <= '0;
        hrdata_q <= HRDATA;
      end else if (in_rd) begin
        wait_cnt <= wait_cnt + TW'(1);
      end

      if (rd_miss)
        err_mismatch <= 1'b1;
      if (rd_tmo)
        err_timeout <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_wp <= '0;
      rd_rp <= '0;
      wr_wp <= '0;
      wr_rp <= '0;
    end else begin
      if (rd_push)
        rd_wp <= rd_wp + (RAW+1)'(1);
      if (rd_pop)
        rd_rp <= rd_rp + (RAW+1)'(1);
      if (wr_push)
        wr_wp <= wr_wp + (WAW+1)'(1);
      if (wr_pop)
        wr_rp <= wr_rp + (WAW+1)'(1);
    end
  end

  // Storage needs no reset: reset only clears the pointers.
  always_ff @(posedge HCLK) begin
    if (rd_push) begin
      rd_addr_mem[rd_wp[RAW-1:0]] <= rd_push_addr;
      rd_data_mem[rd_wp[RAW-1:0]] <= rd_push_data;
    end
    if (wr_push) begin
      wr_addr_mem[wr_wp[WAW-1:0]] <= addr_d;
      wr_data_mem[wr_wp[WAW-1:0]] <= HWDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq <= '0;
      fiq <= 1'b0;
    end else if (irq_set_valid) begin
      irq <= irq_set_vec;
      fiq <= fiq_set;
    end
  end

endmodule

// File: tb/tb_io_fwd_queue.sv
// tb/tb_io_fwd_queue.sv - randomized bench for io_fwd_queue against a queue-based model
module tb_io_fwd_queue;

  localparam int          RD_DEPTH = 16;
  localparam int          WR_DEPTH = 8;
  localparam int          NUM_IRQ  = 4;
  localparam int          TIMEOUT  = 64;
  localparam logic [31:0] BAD      = 32'hDEADBEEF;

  logic                HCLK = 1'b0;
  logic                HRESETn;
  logic                HSEL;
  logic                HREQUEST;
  logic [31:0]         HADDR;
  logic                HWRITE;
  logic [31:0]         HWDATA;
  logic [31:0]         HRDATA;
  logic                HREADY;
  logic                rd_push_valid;
  logic                rd_push_ready;
  logic [31:0]         rd_push_addr;
  logic [31:0]         rd_push_data;
  logic                wr_log_valid;
  logic                wr_log_ready;
  logic [31:0]         wr_log_addr;
  logic [31:0]         wr_log_data;
  logic                irq_set_valid;
  logic [NUM_IRQ-1:0]  irq_set_vec;
  logic                fiq_set;
  logic [NUM_IRQ-1:0]  irq;
  logic                fiq;
  logic                err_mismatch;
  logic                err_timeout;
  logic [4:0]          rd_count;

  always #5 HCLK = ~HCLK;

  io_fwd_queue #(
    .RD_DEPTH(RD_DEPTH), .WR_DEPTH(WR_DEPTH), .NUM_IRQ(NUM_IRQ),
    .TIMEOUT(TIMEOUT), .BAD_DATA(BAD)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREQUEST(HREQUEST),
    .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .rd_push_valid(rd_push_valid), .rd_push_ready(rd_push_ready),
    .rd_push_addr(rd_push_addr), .rd_push_data(rd_push_data),
    .wr_log_valid(wr_log_valid), .wr_log_ready(wr_log_ready),
    .wr_log_addr(wr_log_addr), .wr_log_data(wr_log_data),
    .irq_set_valid(irq_set_valid), .irq_set_vec(irq_set_vec), .fiq_set(fiq_set),
    .irq(irq), .fiq(fiq), .err_mismatch(err_mismatch), .err_timeout(err_timeout),
    .rd_count(rd_count)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t               rq[$];
  ent_t               wq[$];
  int                 ph;
  logic [31:0]        ph_addr;
  int                 waited;
  logic [31:0]        last_rd;
  logic [NUM_IRQ-1:0] m_irq;
  logic               m_fiq;
  logic               m_mm;
  logic               m_to;

  int          checks   = 0;
  int          failures = 0;
  int          push_at  = -1;
  int          pop_at   = -1;
  bit          rand_host = 1'b0;
  bit          drain     = 1'b0;
  logic [31:0] push_a;
  logic [31:0] push_d;
  int          stalls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    wq.delete();
    ph = 0; ph_addr = '0; waited = 0; last_rd = '0;
    m_irq = '0; m_fiq = 1'b0; m_mm = 1'b0; m_to = 1'b0;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit done, hit, miss, tmo, rpush, wpop, wpush;
    logic [31:0] exp_d;
    @(negedge HCLK);
    done = 1'b1; hit = 1'b0; miss = 1'b0; tmo = 1'b0; exp_d = last_rd;
    if (ph == 1) begin
      done = (wq.size() < WR_DEPTH);
    end else if (ph == 2) begin
      if (rq.size() > 0) begin
        hit   = (rq[0].a == ph_addr);
        miss  = !hit;
        exp_d = hit ? rq[0].d : BAD;
      end else if (waited == TIMEOUT) begin
        tmo   = 1'b1;
        exp_d = BAD;
      end else begin
        done = 1'b0;
      end
    end
    chk("hready", 32'(HREADY), 32'(done));
    chk("hrdata", HRDATA, exp_d);
    chk("rd_count", 32'(rd_count), 32'(rq.size()));
    chk("rd_push_ready", 32'(rd_push_ready), 32'(rq.size() < RD_DEPTH));
    chk("wr_log_valid", 32'(wr_log_valid), 32'(wq.size() > 0));
    if (wq.size() > 0) begin
      chk("wr_log_addr", wr_log_addr, wq[0].a);
      chk("wr_log_data", wr_log_data, wq[0].d);
    end
    chk("irq", 32'(irq), 32'(m_irq));
    chk("fiq", 32'(fiq), 32'(m_fiq));
    chk("err_mismatch", 32'(err_mismatch), 32'(m_mm));
    chk("err_timeout", 32'(err_timeout), 32'(m_to));
    @(posedge HCLK);
    rpush = rd_push_valid && (rq.size() < RD_DEPTH);
    wpop  = wr_log_ready && (wq.size() > 0);
    wpush = (ph == 1) && done;
    if (wpop) void'(wq.pop_front());
    if (wpush) wq.push_back({ph_addr, HWDATA});
    if (hit) void'(rq.pop_front());
    if (rpush) rq.push_back({rd_push_addr, rd_push_data});
    if (miss) m_mm = 1'b1;
    if (tmo) m_to = 1'b1;
    if (ph == 2 && done) last_rd = exp_d;
    waited = (ph == 2 && !done) ? waited + 1 : 0;
    if (irq_set_valid) begin
      m_irq = irq_set_vec;
      m_fiq = fiq_set;
    end
    if (done && HSEL && HREQUEST) begin
      ph      = HWRITE ? 1 : 2;
      ph_addr = HADDR;
    end else if (done) begin
      ph = 0;
    end
    #1;
  endtask

  task automatic host_drive(input int n);
    if (rand_host) begin
      rd_push_valid = ($urandom_range(0, 2) == 0);
      rd_push_addr  = 32'h100 + 32'($urandom_range(0, 3) * 4);
      rd_push_data  = $urandom;
      wr_log_ready  = ($urandom_range(0, 1) == 1);
      irq_set_valid = ($urandom_range(0, 9) == 0);
      irq_set_vec   = NUM_IRQ'($urandom);
      fiq_set       = 1'($urandom);
    end else begin
      rd_push_valid = (n >= 0) && (n == push_at);
      rd_push_addr  = push_a;
      rd_push_data  = push_d;
      wr_log_ready  = drain || ((n >= 0) && (n == pop_at));
      irq_set_valid = 1'b0;
    end
  endtask

  task automatic idle(input int k);
    HSEL = 1'b0; HREQUEST = 1'b0;
    for (int i = 0; i < k; i++) begin
      host_drive(-1);
      cycle();
    end
  endtask

  task automatic push_rd(input logic [31:0] a, input logic [31:0] d);
    rd_push_valid = 1'b1; rd_push_addr = a; rd_push_data = d;
    cycle();
    rd_push_valid = 1'b0;
  endtask

  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] wd, output int st);
    int n;
    HSEL = 1'b1; HREQUEST = 1'b1; HWRITE = w; HADDR = a; HWDATA = $urandom;
    host_drive(-1);
    cycle();
    HSEL = 1'b0; HREQUEST = 1'b0; HWRITE = 1'b0; HADDR = $urandom; HWDATA = wd;
    n = 0;
    while (ph != 0 && n < 200) begin
      host_drive(n);
      cycle();
      n++;
    end
    chk("xfer_bound", 32'(ph), 32'd0);
    st = n - 1;
    host_drive(-1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HREQUEST = 1'b0; HADDR = '0; HWRITE = 1'b0; HWDATA = '0;
    rd_push_valid = 1'b0; rd_push_addr = '0; rd_push_data = '0; wr_log_ready = 1'b0;
    irq_set_valid = 1'b0; irq_set_vec = '0; fiq_set = 1'b0; push_a = '0; push_d = '0;
    model_reset();
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    idle(2);
    chk("reset_hrdata", HRDATA, 32'h0);

    // Back-to-back replayed reads
    push_rd(32'h1000, 32'hAAAA5555);
    push_rd(32'h1004, 32'h12345678);
    chk("t1_count", 32'(rd_count), 32'd2);
    HSEL = 1'b1; HREQUEST = 1'b1; HWRITE = 1'b0; HADDR = 32'h1000;
    cycle();
    HADDR = 32'h1004;
    cycle();
    HSEL = 1'b0; HREQUEST = 1'b0;
    cycle();
    chk("t1_hold", HRDATA, 32'h12345678);
    idle(2);

    // Read that waits for a late push
    push_a = 32'h2000; push_d = 32'hCAFEF00D; push_at = 5;
    xfer(1'b0, 32'h2000, '0, stalls);
    push_at = -1;
    chk("t2_stalls", 32'(stalls), 32'd6);
    chk("t2_hold", HRDATA, 32'hCAFEF00D);
    chk("t2_no_timeout", 32'(err_timeout), 32'd0);

    // Read that times out
    xfer(1'b0, 32'h2100, '0, stalls);
    chk("t3_stalls", 32'(stalls), 32'd64);
    chk("t3_hold", HRDATA, BAD);
    chk("t3_timeout", 32'(err_timeout), 32'd1);

    // Address mismatch keeps the entry
    push_rd(32'h3000, 32'h1);
    xfer(1'b0, 32'h3004, '0, stalls);
    chk("t4_mismatch", 32'(err_mismatch), 32'd1);
    chk("t4_count", 32'(rd_count), 32'd1);
    xfer(1'b0, 32'h3000, '0, stalls);
    chk("t4_hold", HRDATA, 32'h1);

    // Write log fills, stalls, then drains in bus order
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 32'h4000 + 32'(i * 4), $urandom, stalls);
      chk("t5_nostall", 32'(stalls), 32'd0);
    end
    pop_at = 2;
    xfer(1'b1, 32'h4020, 32'h99999999, stalls);
    pop_at = -1;
    chk("t5_stall", 32'(stalls), 32'd3);
    chk("t5_head", wr_log_addr, 32'h4004);
    drain = 1'b1;
    idle(10);
    drain = 1'b0;
    chk("t5_empty", 32'(wr_log_valid), 32'd0);

    // Interrupt load, then reset in the middle of a wait
    irq_set_valid = 1'b1; irq_set_vec = 4'b1010; fiq_set = 1'b1;
    cycle();
    irq_set_valid = 1'b0;
    chk("t6_irq", 32'(irq), 32'hA);
    chk("t6_fiq", 32'(fiq), 32'd1);
    HSEL = 1'b1; HREQUEST = 1'b1; HWRITE = 1'b0; HADDR = 32'h5000;
    cycle();
    HSEL = 1'b0; HREQUEST = 1'b0;
    repeat (5) cycle();
    HRESETn = 1'b0;
    #1;
    chk("t6_rst_hready", 32'(HREADY), 32'd1);
    chk("t6_rst_irq", 32'(irq), 32'd0);
    chk("t6_rst_fiq", 32'(fiq), 32'd0);
    chk("t6_rst_count", 32'(rd_count), 32'd0);
    chk("t6_rst_timeout", 32'(err_timeout), 32'd0);
    chk("t6_rst_hrdata", HRDATA, 32'h0);
    model_reset();
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    idle(3);

    // Randomized traffic with a randomly behaving host
    rand_host = 1'b1;
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    xfer(1'b0, 32'h100 + 32'($urandom_range(0, 3) * 4), '0, stalls);
        2:       xfer(1'b1, $urandom, $urandom, stalls);
        default: idle($urandom_range(1, 3));
      endcase
    end
    rand_host = 1'b0;
    drain = 1'b1;
    idle(20);
    drain = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
